swipt_bridge_pwm: RTL and testbench

- Full-bridge gate-drive generator for the SWIPT transmitter.
- Sits directly downstream of the frequency/power optimisation logic. That logic supplies a period and a pulse length; this block turns them into the four gate signals SWIPT_OUT0..3 (left-up, right-up, left-down, right-down).
- Adds dead-time on every switch transition and applies new settings only on period boundaries, so the bridge never sees a torn cycle or a shoot-through state.

---
 rtl/swipt_pkg.sv | 47 ++++
 rtl/swipt_bridge_pwm_if.sv | 22 ++
 rtl/swipt_phase_timer.sv | 25 ++
 rtl/swipt_bridge_pwm.sv | 203 ++++++++++++++++++++
 tb/tb_swipt_bridge_pwm.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT full-bridge gate-drive generator:
// FSM state encoding, gate patterns {s3,s2,s1,s0} and default timing.
package swipt_pkg;

  typedef enum logic [3:0] {
    ST_PARK,
    ST_POS,
    ST_DEAD_A,
    ST_FREE_P,
    ST_DEAD_B,
    ST_NEG,
    ST_DEAD_C,
    ST_FREE_N,
    ST_DEAD_D
  } swipt_state_e;

  // s0 = left-up, s1 = right-up, s2 = left-down, s3 = right-down
  localparam logic [3:0] GATE_PARK   = 4'b1100;
  localparam logic [3:0] GATE_POS    = 4'b1001;
  localparam logic [3:0] GATE_NEG    = 4'b0110;
  localparam logic [3:0] GATE_DEAD_P = 4'b1000;  // s3 shared by POS and freewheel
  localparam logic [3:0] GATE_DEAD_N = 4'b0100;  // s2 shared by NEG and freewheel

  // 50 MHz / 40 kHz, 96 % of the half-period; shared with the optimiser
  localparam int unsigned SWIPT_DEF_PERIOD = 1250;
  localparam int unsigned SWIPT_DEF_ON     = 600;

  // Dead states next to a pulse hold only the switch common to both
  // neighbours; in a period without pulses (dark) everything is freewheel.
  function automatic logic [3:0] gate_for(swipt_state_e s, logic dark);
    logic [3:0] g;
    g = GATE_PARK;
    case (s)
      ST_POS:               g = GATE_POS;
      ST_NEG:               g = GATE_NEG;
      ST_DEAD_A, ST_DEAD_D: g = dark ? GATE_PARK : GATE_DEAD_P;
      ST_DEAD_B, ST_DEAD_C: g = dark ? GATE_PARK : GATE_DEAD_N;
      default:              g = GATE_PARK;
    endcase
    return g;
  endfunction

  function automatic logic is_neg_half(swipt_state_e s);
    return (s == ST_NEG) || (s == ST_DEAD_C) || (s == ST_FREE_N) || (s == ST_DEAD_D);
  endfunction

endpackage

// File: rtl/swipt_bridge_pwm_if.sv
// Configuration handshake between the frequency/power optimiser (master)
// and the bridge gate-drive generator (slave).
interface swipt_bridge_pwm_if #(
  parameter int unsigned PERIOD_W = 13,
  parameter int unsigned ON_W     = 12
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [PERIOD_W-1:0] cfg_period;
  logic [ON_W-1:0]     cfg_on;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_period, cfg_on,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_on,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/swipt_phase_timer.sv
// Loadable down-counter timing one FSM phase; o_done while the count is 0.
module swipt_phase_timer #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  // load phase length - 1 on state entry, otherwise count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/swipt_bridge_pwm.sv
// Full-bridge gate-drive generator for the SWIPT transmitter.
// Turns a period / pulse length into four dead-time protected gate signals;
// new settings are applied only on period boundaries.
// Optional macro SWIPT_PWM_DATA_EN adds amplitude-keyed data ports
// (data_bit, data_on, data_taken).
module swipt_bridge_pwm
  import swipt_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 13,
  parameter int unsigned ON_W       = 12,
  parameter int unsigned DEADTIME   = 2,
  parameter int unsigned RST_PERIOD = SWIPT_DEF_PERIOD,
  parameter int unsigned RST_ON     = SWIPT_DEF_ON
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  swipt_bridge_pwm_if.slave   cfg,
`ifdef SWIPT_PWM_DATA_EN
  input  logic                data_bit,
  input  logic [ON_W-1:0]     data_on,
  output logic                data_taken,
`endif
  output logic [3:0]          gate,
  output logic                period_start,
  output logic                half_sel
);

  typedef logic [PERIOD_W-1:0] cnt_t;

  localparam cnt_t DT         = cnt_t'(DEADTIME);
  localparam cnt_t DEAD2      = cnt_t'(2 * DEADTIME);
  localparam cnt_t DEAD2P1    = cnt_t'(2 * DEADTIME + 1);
  localparam cnt_t MIN_PERIOD = cnt_t'(4 * DEADTIME + 4);

  localparam int unsigned RST_HALF   = RST_PERIOD / 2;
  localparam int unsigned RST_LIM    = RST_HALF - 2 * DEADTIME - 1;
  localparam int unsigned RST_ON_EFF = (RST_ON < RST_LIM) ? RST_ON : RST_LIM;
  localparam int unsigned RST_FREE_P = RST_HALF - RST_ON_EFF - 2 * DEADTIME;
  localparam int unsigned RST_FREE_N = RST_FREE_P + (RST_PERIOD % 2);

  swipt_state_e    r_state;
  cnt_t            r_period;
  logic [ON_W-1:0] r_on;
  cnt_t            r_on_eff;
  cnt_t            r_free_p;
  cnt_t            r_free_n;
  logic [3:0]      r_gate;
  logic            r_period_start;
  logic            r_half_sel;
  logic            r_cfg_err;

  logic            w_done;
  logic            w_bnd;
  logic            w_ready;
  logic            w_cfg_ok;
  logic            w_take;
  cnt_t            w_per;
  cnt_t            w_on_req;
  cnt_t            w_half;
  cnt_t            w_lim;
  cnt_t            w_on_eff;
  cnt_t            w_free_p;
  cnt_t            w_free_n;
  swipt_state_e    w_next;
  cnt_t            w_len;
  cnt_t            w_load_val;
  logic            w_adv;
  logic            w_dark;

  // Period boundary is the last DEAD_D cycle. A config accepted there is
  // bypassed straight into the phase-length computation so the very next
  // period already uses it, while the shadow registers catch up at the edge.
  always_comb begin
    w_bnd    = (r_state == ST_DEAD_D) && w_done;
    w_ready  = cfg.cfg_valid && ((r_state == ST_PARK) || w_bnd);
    w_cfg_ok = (cnt_t'(cfg.cfg_period) >= MIN_PERIOD);
    w_take   = w_ready && w_cfg_ok;
    w_per    = w_take ? cnt_t'(cfg.cfg_period) : r_period;
    w_on_req = w_take ? cnt_t'(cfg.cfg_on) : cnt_t'(r_on);
`ifdef SWIPT_PWM_DATA_EN
    if (data_bit) w_on_req = cnt_t'(data_on);
`endif
    w_half   = w_per >> 1;
    w_lim    = w_half - DEAD2P1;
    w_on_eff = (w_on_req < w_lim) ? w_on_req : w_lim;
    w_free_p = w_half - w_on_eff - DEAD2;
    w_free_n = w_free_p + cnt_t'(w_per[0]);
  end

  // Next-state and phase length; en is only honoured after DEAD_B/DEAD_D
  always_comb begin
    w_next = r_state;
    w_len  = DT;
    w_adv  = 1'b0;
    if (r_state == ST_PARK) begin
      if (en) begin
        w_adv  = 1'b1;
        w_next = ST_DEAD_D;
      end
    end else if (w_done) begin
      w_adv = 1'b1;
      unique case (r_state)
        ST_POS:    w_next = ST_DEAD_A;
        ST_DEAD_A: begin w_next = ST_FREE_P; w_len = r_free_p; end
        ST_FREE_P: w_next = ST_DEAD_B;
        ST_DEAD_B: begin
          if (!en) begin
            w_next = ST_PARK;
            w_len  = cnt_t'(1);
          end else if (r_on_eff == '0) begin
            w_next = ST_DEAD_C;
          end else begin
            w_next = ST_NEG;
            w_len  = r_on_eff;
          end
        end
        ST_NEG:    w_next = ST_DEAD_C;
        ST_DEAD_C: begin w_next = ST_FREE_N; w_len = r_free_n; end
        ST_FREE_N: w_next = ST_DEAD_D;
        ST_DEAD_D: begin
          if (!en) begin
            w_next = ST_PARK;
            w_len  = cnt_t'(1);
          end else if (w_on_eff == '0) begin
            w_next = ST_DEAD_A;
          end else begin
            w_next = ST_POS;
            w_len  = w_on_eff;
          end
        end
        default: begin
          w_next = ST_PARK;
          w_len  = cnt_t'(1);
        end
      endcase
    end
    w_load_val = w_len - 1'b1;
    w_dark     = (r_state == ST_DEAD_D) ? (w_on_eff == '0) : (r_on_eff == '0);
  end

  swipt_phase_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_adv),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // FSM with registered gate/half/pulse outputs and shadow config
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_PARK;
      r_gate         <= GATE_PARK;
      r_half_sel     <= 1'b0;
      r_period_start <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_period       <= cnt_t'(RST_PERIOD);
      r_on           <= ON_W'(RST_ON);
      r_on_eff       <= cnt_t'(RST_ON_EFF);
      r_free_p       <= cnt_t'(RST_FREE_P);
      r_free_n       <= cnt_t'(RST_FREE_N);
    end else begin
      if (w_adv) begin
        r_state    <= w_next;
        r_gate     <= gate_for(w_next, w_dark);
        r_half_sel <= is_neg_half(w_next);
      end
      r_period_start <= w_adv && ((w_next == ST_POS) ||
                                  ((w_next == ST_DEAD_A) && (r_state == ST_DEAD_D)));
      r_cfg_err      <= w_ready && !w_cfg_ok;
      if (w_take) begin
        r_period <= cfg.cfg_period;
        r_on     <= cfg.cfg_on;
      end
      if (w_bnd) begin
        r_on_eff <= w_on_eff;
        r_free_p <= w_free_p;
        r_free_n <= w_free_n;
      end
    end
  end

`ifdef SWIPT_PWM_DATA_EN
  logic r_data_taken;

  // data_bit is consumed together with the period it keyed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_data_taken <= 1'b0;
    else     r_data_taken <= w_adv && ((w_next == ST_POS) ||
                                       ((w_next == ST_DEAD_A) && (r_state == ST_DEAD_D)));
  end

  assign data_taken = r_data_taken;
`endif

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_err   = r_cfg_err;
  assign gate          = r_gate;
  assign period_start  = r_period_start;
  assign half_sel      = r_half_sel;

endmodule

// File: tb/tb_swipt_bridge_pwm.sv
// Self-checking bench for swipt_bridge_pwm (default build, DEADTIME = 2).
module tb_swipt_bridge_pwm;
  localparam int DT = 2;

  typedef struct {
    int total;
    int pos;
    int neg;
    int free_p;
    int free_all;
  } per_t;

  typedef struct {
    int period;
    int on;
    bit err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] gate;
  logic       period_start;
  logic       half_sel;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  per_t sb_q[$];
  int   cur_per = 1250;
  int   cur_on  = 600;

  swipt_bridge_pwm_if #(.PERIOD_W(13), .ON_W(12)) cfg_if ();

  swipt_bridge_pwm #(
    .PERIOD_W   (13),
    .ON_W       (12),
    .DEADTIME   (DT),
    .RST_PERIOD (1250),
    .RST_ON     (600)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg          (cfg_if),
    .gate         (gate),
    .period_start (period_start),
    .half_sel     (half_sel)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // left leg s0/s2 and right leg s1/s3 must never conduct together
  always @(negedge clk) begin
    if (mon_on) begin
      n_cmp++;
      assert (!(gate[0] && gate[2]) && !(gate[1] && gate[3]))
      else begin
        n_fail++;
        $display("FAIL leg_overlap: gate=%b at %0t", gate, $time);
      end
    end
  end

  function automatic per_t model(input int p, input int on);
    per_t r;
    int half, lim, oe, fp;
    half = p / 2;
    lim  = half - 2 * DT - 1;
    oe   = (on < lim) ? on : lim;
    fp   = half - oe - 2 * DT;
    r.total    = p;
    r.pos      = oe;
    r.neg      = oe;
    r.free_p   = (oe > 0) ? fp : half;
    r.free_all = (oe > 0) ? (2 * fp + p % 2) : p;
    return r;
  endfunction

  // Starts on the period_start sample, stops on the next one
  task automatic measure(output per_t m);
    int n;
    m = '{default: 0};
    n = 0;
    do begin
      m.total++;
      if (gate == 4'b1001) m.pos++;
      if (gate == 4'b0110) m.neg++;
      if (gate == 4'b1100) begin
        m.free_all++;
        if (!half_sel) m.free_p++;
      end
      @(negedge clk);
      n++;
    end while (!period_start && n < 5000);
    if (n >= 5000) check("measure_timeout", n, 0);
  endtask

  task automatic compare_period(input string tag);
    per_t m, e;
    measure(m);
    e = sb_q.pop_front();
    check({tag, "_total"},    m.total,    e.total);
    check({tag, "_pos"},      m.pos,      e.pos);
    check({tag, "_neg"},      m.neg,      e.neg);
    check({tag, "_free_p"},   m.free_p,   e.free_p);
    check({tag, "_free_all"}, m.free_all, e.free_all);
  endtask

  // Entered on a period_start sample; offers the config a few cycles into
  // the period, expects acceptance only at the end of that period.
  task automatic run_vec(input string tag, input int p, input int on, input bit exp_err);
    int waited;
    repeat (3) @(negedge clk);
    cfg_if.cfg_period = 13'(p);
    cfg_if.cfg_on     = 12'(on);
    cfg_if.cfg_valid  = 1'b1;
    waited = 0;
    #1;
    while (!cfg_if.cfg_ready && waited < 5000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({tag, "_ready_wait"}, waited, cur_per - 4);
    if (!exp_err) begin
      cur_per = p;
      cur_on  = on;
    end
    sb_q.push_back(model(cur_per, cur_on));
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check({tag, "_cfg_err"}, int'(cfg_if.cfg_err), int'(exp_err));
    check({tag, "_period_start"}, int'(period_start), 1);
    compare_period(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   n, c_pos, c_neg, c_ps, p, on;

    vecs[0] = '{1000, 480, 1'b0};  // offered mid-POS
    vecs[1] = '{1250, 700, 1'b0};  // on clamped to 620, FREE_P = 1
    vecs[2] = '{10,   5,   1'b1};  // period too short: rejected
    vecs[3] = '{1251, 600, 1'b0};  // odd period: extra cycle to FREE_N
    vecs[4] = '{1250, 0,   1'b0};  // no pulses, constant freewheel
    vecs[5] = '{12,   9,   1'b0};  // shortest legal period
    vecs[6] = '{11,   3,   1'b1};  // one below the limit
    vecs[7] = '{1250, 600, 1'b0};

    rst = 1'b1;
    en  = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_on     = '0;
    repeat (2) @(negedge clk);
    check("rst_gate", int'(gate), 12);
    check("rst_period_start", int'(period_start), 0);
    check("rst_half_sel", int'(half_sel), 0);
    check("rst_cfg_err", int'(cfg_if.cfg_err), 0);

    rst    = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    check("parked_gate", int'(gate), 12);

    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 100);
    check("start_latency", n, DT + 1);
    sb_q.push_back(model(1250, 600));
    sb_q.push_back(model(1250, 600));
    compare_period("def0");
    compare_period("def1");

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].period, vecs[i].on, vecs[i].err);

    for (int i = 0; i < 100; i++) begin
      p  = $urandom_range(8, 120);
      on = $urandom_range(0, 70);
      run_vec("rnd", p, on, p < 4 * DT + 4);
    end
    run_vec("restore", 1250, 600, 1'b0);

    // en dropped in POS: the pulse finishes, the bridge parks after DEAD_B
    c_pos = 0;
    c_neg = 0;
    c_ps  = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 3) en = 1'b0;
      if (gate == 4'b1001) c_pos++;
      if (gate == 4'b0110) c_neg++;
      if (i > 0 && period_start) c_ps++;
      @(negedge clk);
    end
    check("park_pos_cycles", c_pos, 600);
    check("park_neg_cycles", c_neg, 0);
    check("park_period_starts", c_ps, 0);
    check("park_gate", int'(gate), 12);
    check("park_half_sel", int'(half_sel), 0);

    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 100);
    check("restart_latency", n, DT + 1);

    n = 0;
    while (!(half_sel && gate == 4'b0110) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_neg_gate", int'(gate), 6);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_gate", int'(gate), 12);
    check("async_rst_half_sel", int'(half_sel), 0);
    check("async_rst_period_start", int'(period_start), 0);
    @(negedge clk);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
